ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised iterative multiply/divide unit for the EX stage; it gives the execute path a multi-cycle HI/LO engine. It accepts one MULT/MULTU/DIV/DIVU operation (plus MADD/MSUB variants when configured), holds the pipeline through `stallreq_o` while iterating, and returns a 2×WIDTH {HI,LO} result with a one-cycle `ready_o` pulse. The HI/LO write-back, forwarding and CP0/exception flush logic sit outside the block.

## Interface
- `WIDTH`, default 32: operand width; result is 2×WIDTH; must be a power of two ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `start_i`  in  1  operation request; held high by EX for as long as the instruction sits in EX.
- `op_i`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `opa_i`, `opb_i`  in  WIDTH  rs/rt operands (dividend/divisor for divide).
- `hi_i`, `lo_i`  in  WIDTH  forwarded HI/LO value, the accumulator for MADD/MSUB.
- `annul_i`  in  1  flush; cancels any operation in flight.
- `result_o`  out  2×WIDTH  {HI,LO}, registered.
- `ready_o`  out  1  result valid; one-cycle pulse.
- `busy_o`  out  1  high while the state is CALC or DONE.
- `stallreq_o`  out  1  combinational stall request to the pipeline controller.

## Operation
- FSM states are IDLE, CALC and DONE. `start_i` is sampled only in IDLE.
- IDLE → CALC when `start_i` is high, the op is valid and `annul_i` is low.
- On acceptance the block captures the operands, `hi_i`/`lo_i` and the op.
  - Signed ops convert both operands to magnitudes.
  - The iteration counter loads WIDTH.
- CALC does one bit per cycle.
  - Multiply: radix-2 shift-add on the magnitudes.
  - Divide: restoring algorithm on the magnitudes.
- When the counter reaches 0, the block applies sign fix-up, writes `result_o` and moves to DONE.
- DONE → IDLE unconditionally, so a `start_i` still high in DONE is never relaunched.
- Signed multiply: the product is negated when the operand signs differ.
- Signed divide:
  - Quotient (LO) is negative when the operand signs differ.
  - Remainder (HI) takes the sign of the dividend.
  - 0x80000000 / −1 (WIDTH = 32) gives LO = 0x80000000, HI = 0. This is wrap-around, not a trap.
- Divide by zero (`opb_i` = 0) is detected in IDLE and skips CALC: IDLE → DONE with LO = all-ones and HI = `opa_i`, for both signed and unsigned divide.
- `annul_i` has highest priority after reset.
  - Any state → IDLE on the next edge.
  - `ready_o` is never raised for the annulled op and `result_o` keeps its previous value.
  - `start_i` together with `annul_i` in IDLE is not accepted.
- Reset (`rst` low at an edge) puts the FSM in IDLE, clears the counter, and sets `result_o` = 0, `ready_o` = 0, `busy_o` = 0. Reset in the middle of an operation abandons it.

## Timing
- Launch: cycle 0 is IDLE with `start_i` high. CALC occupies cycles 1..WIDTH. DONE is cycle WIDTH+1, where `ready_o` = 1 and `result_o` is valid.
- Divide by zero: DONE is cycle 1.
- `stallreq_o` = `rst` & ~`annul_i` & ((IDLE & `start_i` & valid op) | CALC). It is low in DONE, so the pipeline advances on the edge that ends DONE and the result is consumed in that cycle.
- `busy_o` and `ready_o` are registered, decoded from the state.
- Back-to-back ops: a new `start_i` in the IDLE cycle after DONE is accepted. The minimum issue interval is WIDTH+2 cycles.
- `hi_i`/`lo_i` are sampled only on acceptance; later changes are ignored.

## Configuration
- `EX_MULDIV_MACC_EN` defined:
  - ops 4–7 are valid.
  - On completion, `result_o` = {`hi_i`,`lo_i`} captured at acceptance ± the product, modulo 2^(2×WIDTH).
  - MADD/MSUB are signed; MADDU/MSUBU are unsigned.
  - No extra latency.
- `EX_MULDIV_MACC_EN` undefined:
  - ops 4–7 are invalid: not accepted, `stallreq_o` stays 0, no `ready_o`, FSM remains in IDLE.
  - No accumulator adder is built.

## Test plan
- MULT −3 × 5, WIDTH = 32 → `stallreq_o` high for cycles 0..32, `ready_o` at cycle 33, `result_o` = 0xFFFFFFFF_FFFFFFF1.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 7 / 0 → `ready_o` at cycle 1, LO = 0xFFFFFFFF, HI = 7, then 0x12345678 / 0x10 → LO = 0x01234567, HI = 8.
- Start MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - Pulse `annul_i` at cycle 10 → IDLE at cycle 11, no `ready_o`, `result_o` unchanged.
  - Repeat the op and instead drive `rst` low at cycle 10 → `result_o` = 0 and `busy_o` = 0 at cycle 11.
  - Repeat the op uninterrupted → 0xFFFFFFFE_00000001.
- With `EX_MULDIV_MACC_EN`:
  - MADDU 1 × 1 with HI = 0, LO = 0xFFFFFFFF → {0x00000001, 0x00000000}.
  - MSUB 2 × 3 with {0,0} → 0xFFFFFFFF_FFFFFFFA.
  - Without the macro, op 4 → no stall, no `ready_o`.
- Hold `start_i` high through DONE → exactly one `ready_o`. A new MULT 2 × 2 issued the cycle after DONE → accepted, result 4.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide engine for the EX stage.
// One MULT/MULTU/DIV/DIVU operation at a time, one bit per cycle. The
// pipeline is held through stallreq_o. The {HI,LO} result is returned
// with a single-cycle ready_o pulse.
// Optional feature: define EX_MULDIV_MACC_EN to enable MADD/MADDU/MSUB/MSUBU.
// These ops accumulate into the {hi_i,lo_i} value captured at acceptance.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [WIDTH-1:0]     opa_i,
   input  logic [WIDTH-1:0]     opb_i,
   input  logic [WIDTH-1:0]     hi_i,
   input  logic [WIDTH-1:0]     lo_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 stallreq_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   // Decoded view of the incoming request
   logic             op_valid;
   logic             op_div;
   logic             op_signed;
   logic             sign_a;
   logic             sign_b;
   logic             div_by_zero;
   logic             accept;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   // Iteration state captured at acceptance
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;
   logic [WIDTH-1:0] mcand;
   logic             div_q;
   logic             neg_q;
   logic             neg_rem_q;

   // One-step datapath and final fix-up
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] raw_prod;
   logic [2*WIDTH-1:0] signed_prod;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] final_res;

`ifdef EX_MULDIV_MACC_EN
   logic               op_macc;
   logic               op_sub;
   logic               macc_q;
   logic               sub_q;
   logic [2*WIDTH-1:0] acc_q;
`else
   logic               unused_acc_inputs;
   assign unused_acc_inputs = ^{hi_i, lo_i};
`endif

   // Decode the request and take operand magnitudes for signed ops.
   // Without the MACC build, ops 4-7 are treated as invalid.
   // Bit 0 of the op code selects unsigned. Bit 1 selects divide,
   // or subtract for the MACC group. Bit 2 selects the MACC group.
   always_comb begin
      op_signed = ~op_i[0];
      op_div    = ~op_i[2] & op_i[1];
`ifdef EX_MULDIV_MACC_EN
      op_valid  = 1'b1;
      op_macc   = op_i[2];
      op_sub    = op_i[2] & op_i[1];
`else
      op_valid  = ~op_i[2];
`endif
      sign_a      = op_signed & opa_i[WIDTH-1];
      sign_b      = op_signed & opb_i[WIDTH-1];
      mag_a       = sign_a ? -opa_i : opa_i;
      mag_b       = sign_b ? -opb_i : opb_i;
      div_by_zero = op_div & (opb_i == '0);
      accept      = (state == IDLE) & start_i & op_valid & ~annul_i;
   end

   // State register, plus busy/ready decoded from the upcoming state
   // so that both outputs line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         busy_o  <= 1'b0;
         ready_o <= 1'b0;
      end else begin
         state   <= state_next;
         busy_o  <= (state_next != IDLE);
         ready_o <= (state_next == DONE);
      end
   end

   // Next-state logic. A divide by zero jumps straight to DONE, and
   // annul overrides everything.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = div_by_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == CNT_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (annul_i) begin
         state_next = IDLE;
      end
   end

   // Stall request. It is low in DONE, so the pipeline moves on as the
   // result is consumed.
   always_comb begin
      stallreq_o = rst & ~annul_i &
                   (((state == IDLE) & start_i & op_valid) | (state == CALC));
   end

   // One iteration step. Multiply: add the multiplicand when the low bit
   // of the multiplier is set, then shift the {p_hi,p_lo} pair right.
   // Divide: shift the next dividend bit into the remainder, then subtract
   // the divisor. The top bit of the difference flags a borrow, in which
   // case the remainder is kept (restored).
   always_comb begin
      mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
      div_trial = {p_hi, p_lo[WIDTH-1]};
      div_diff  = div_trial - {1'b0, mcand};
      if (div_q) begin
         if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {p_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {p_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
      end
   end

   // Sign fix-up on the last step's output. The quotient and the product
   // take the XOR of the operand signs. The remainder follows the dividend.
   // The MACC ops fold the signed product into the captured accumulator,
   // modulo 2^(2*WIDTH).
   always_comb begin
      raw_prod    = {step_hi, step_lo};
      signed_prod = neg_q ? -raw_prod : raw_prod;
      quo_fix     = neg_q ? -step_lo : step_lo;
      rem_fix     = neg_rem_q ? -step_hi : step_hi;
      if (div_q) begin
         final_res = {rem_fix, quo_fix};
      end else begin
`ifdef EX_MULDIV_MACC_EN
         if (macc_q) begin
            final_res = sub_q ? (acc_q - signed_prod) : (acc_q + signed_prod);
         end else begin
            final_res = signed_prod;
         end
`else
         final_res = signed_prod;
`endif
      end
   end

   // Datapath registers. On acceptance, capture the operands and the op.
   // A divide by zero writes its fixed result at that point. In CALC,
   // advance one bit per cycle, and write the result on the last step
   // unless the op is annulled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         result_o  <= '0;
         p_hi      <= '0;
         p_lo      <= '0;
         mcand     <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
`ifdef EX_MULDIV_MACC_EN
         macc_q    <= 1'b0;
         sub_q     <= 1'b0;
         acc_q     <= '0;
`endif
      end else if (accept) begin
         cnt       <= CNT_LOAD;
         p_hi      <= '0;
         p_lo      <= op_div ? mag_a : mag_b;
         mcand     <= op_div ? mag_b : mag_a;
         div_q     <= op_div;
         neg_q     <= sign_a ^ sign_b;
         neg_rem_q <= sign_a;
`ifdef EX_MULDIV_MACC_EN
         macc_q    <= op_macc;
         sub_q     <= op_sub;
         acc_q     <= {hi_i, lo_i};
`endif
         if (div_by_zero) begin
            result_o <= {opa_i, {WIDTH{1'b1}}};
         end
      end else if ((state == CALC) && !annul_i) begin
         p_hi <= step_hi;
         p_lo <= step_lo;
         cnt  <= cnt - CNT_LAST;
         if (cnt == CNT_LAST) begin
            result_o <= final_res;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv (WIDTH = 32)
// against an arithmetic reference model.
module tb_ex_muldiv;

   localparam int WIDTH = 32;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;
   logic        stallreq_o;

   int checks = 0;
   int errors = 0;

   ex_muldiv #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .opa_i      (opa_i),
      .opb_i      (opb_i),
      .hi_i       (hi_i),
      .lo_i       (lo_i),
      .annul_i    (annul_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .stallreq_o (stallreq_o)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected {HI,LO} from plain integer arithmetic
   function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, acc, prod, uq, ur;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      acc = {h, l};
      case (op)
         3'd0: return 64'(sa * sb);
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         default: begin
            prod = op[0] ? (ua * ub) : 64'(sa * sb);
            return op[1] ? (acc - prod) : (acc + prod);
         end
      endcase
   endfunction

   // Issue one op (cycle 0 = IDLE with start high), scramble the inputs
   // after acceptance, hold start through DONE, and report what happened
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input int max_cyc,
                         output int rdy_cyc, output int rdy_cnt, output int stall_cnt,
                         output logic [63:0] res);
      rdy_cyc   = -1;
      rdy_cnt   = 0;
      stall_cnt = 0;
      res       = '0;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (stallreq_o) stall_cnt++;
         if (ready_o) begin
            rdy_cnt++;
            if (rdy_cyc < 0) begin
               rdy_cyc = c;
               res     = result_o;
            end
         end
         if (rdy_cyc >= 0 && c >= rdy_cyc + 3) break;
         @(posedge clk); #1;
         if (c == 0) begin
            opa_i = ~a; opb_i = ~b; hi_i = ~h; lo_i = ~l;
         end
         if (rdy_cyc >= 0 && c == rdy_cyc) start_i = 1'b0;
      end
      start_i = 1'b0;
   endtask

   // Reset state, with start held high during reset
   task automatic test_reset();
      rst = 1'b0; start_i = 1'b1; op_i = 3'd1; opa_i = 32'd3; opb_i = 32'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (result_o !== 64'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
      checks++;
      if (stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stallreq_o); end
      @(posedge clk); #1;
      rst = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   // MULT -3 x 5: latency, stall window, single ready
   task automatic test_mult();
      int rc, rn, sc; logic [63:0] res;
      run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("[TB] FAIL mult_result: got %h expected FFFFFFFFFFFFFFF1", res); end
      checks++;
      if (rc !== 33) begin errors++; $display("[TB] FAIL mult_ready_cycle: got %0d expected 33", rc); end
      checks++;
      if (sc !== 33) begin errors++; $display("[TB] FAIL mult_stall_cycles: got %0d expected 33", sc); end
      checks++;
      if (rn !== 1) begin errors++; $display("[TB] FAIL mult_ready_count: got %0d expected 1", rn); end
   endtask

   // Signed divide including the most-negative / -1 wrap case
   task automatic test_divide();
      int rc, rn, sc; logic [63:0] res;
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("[TB] FAIL div_neg7_by_2: got %h expected FFFFFFFFFFFFFFFD", res); end
      checks++;
      if (rc !== 33) begin errors++; $display("[TB] FAIL div_ready_cycle: got %0d expected 33", rc); end
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'h0000_0000_8000_0000) begin errors++; $display("[TB] FAIL div_min_by_m1: got %h expected 0000000080000000", res); end
   endtask

   // Divide by zero skips CALC, then a normal DIVU follows
   task automatic test_div_by_zero();
      int rc, rn, sc; logic [63:0] res;
      run_op(3'd3, 32'd7, 32'd0, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'h0000_0007_FFFF_FFFF) begin errors++; $display("[TB] FAIL divu_by_zero: got %h expected 00000007FFFFFFFF", res); end
      checks++;
      if (rc !== 1) begin errors++; $display("[TB] FAIL divz_ready_cycle: got %0d expected 1", rc); end
      checks++;
      if (sc !== 1) begin errors++; $display("[TB] FAIL divz_stall_cycles: got %0d expected 1", sc); end
      run_op(3'd3, 32'h1234_5678, 32'h10, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'h0000_0008_0123_4567) begin errors++; $display("[TB] FAIL divu_after_divz: got %h expected 0000000801234567", res); end
      run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'hFFFF_FFFB_FFFF_FFFF) begin errors++; $display("[TB] FAIL div_signed_by_zero: got %h expected FFFFFFFBFFFFFFFF", res); end
   endtask

   // Annul at cycle 10 of a MULTU, and start+annul together in IDLE
   task automatic test_annul();
      int rc, rn, sc, seen; logic [63:0] res;
      run_op(3'd0, 32'd2, 32'd2, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'd4) begin errors++; $display("[TB] FAIL annul_setup: got %h expected 4", res); end
      seen = 0;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd1; opa_i = 32'hFFFF_FFFF; opb_i = 32'hFFFF_FFFF;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (ready_o) seen++;
         if (c == 10) begin
            checks++;
            if (stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL annul_stall: got %b expected 0", stallreq_o); end
         end
         if (c == 11) begin
            checks++;
            if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL annul_busy: got %b expected 0", busy_o); end
            checks++;
            if (result_o !== 64'd4) begin errors++; $display("[TB] FAIL annul_result_kept: got %h expected 4", result_o); end
         end
         @(posedge clk); #1;
         if (c == 9) begin annul_i = 1'b1; start_i = 1'b0; end
         if (c == 10) annul_i = 1'b0;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL annul_no_ready: got %0d pulses expected 0", seen); end
      // start and annul together in IDLE must not launch
      @(posedge clk); #1;
      start_i = 1'b1; annul_i = 1'b1; op_i = 3'd0; opa_i = 32'd9; opb_i = 32'd9;
      @(negedge clk);
      checks++;
      if (stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL annul_start_stall: got %b expected 0", stallreq_o); end
      @(posedge clk); #1;
      start_i = 1'b0; annul_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_o || busy_o) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL annul_start_launch: got %0d active cycles expected 0", seen); end
   endtask

   // Reset at cycle 10 abandons the op and clears the result
   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd1; opa_i = 32'hFFFF_FFFF; opb_i = 32'hFFFF_FFFF;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (ready_o) seen++;
         if (c == 11) begin
            checks++;
            if (result_o !== 64'd0) begin errors++; $display("[TB] FAIL midreset_result: got %h expected 0", result_o); end
            checks++;
            if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy_o); end
         end
         @(posedge clk); #1;
         if (c == 9) begin rst = 1'b0; start_i = 1'b0; end
         if (c == 10) rst = 1'b1;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL midreset_no_ready: got %0d pulses expected 0", seen); end
   endtask

   // MULTU all-ones squared, uninterrupted
   task automatic test_multu();
      int rc, rn, sc; logic [63:0] res;
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("[TB] FAIL multu_max: got %h expected FFFFFFFE00000001", res); end
      checks++;
      if (rc !== 33) begin errors++; $display("[TB] FAIL multu_ready_cycle: got %0d expected 33", rc); end
   endtask

   // Accumulating ops, or their rejection when not built
   task automatic test_macc();
      int rc, rn, sc; logic [63:0] res;
`ifdef EX_MULDIV_MACC_EN
      run_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'h0000_0001_0000_0000) begin errors++; $display("[TB] FAIL maddu: got %h expected 0000000100000000", res); end
      checks++;
      if (rc !== 33) begin errors++; $display("[TB] FAIL maddu_ready_cycle: got %0d expected 33", rc); end
      run_op(3'd6, 32'd2, 32'd3, 32'd0, 32'd0, 60, rc, rn, sc, res);
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("[TB] FAIL msub: got %h expected FFFFFFFFFFFFFFFA", res); end
`else
      run_op(3'd4, 32'd2, 32'd3, 32'd0, 32'd0, 40, rc, rn, sc, res);
      checks++;
      if (rn !== 0) begin errors++; $display("[TB] FAIL op4_ready: got %0d pulses expected 0", rn); end
      checks++;
      if (sc !== 0) begin errors++; $display("[TB] FAIL op4_stall: got %0d cycles expected 0", sc); end
`endif
   endtask

   // New op issued in the IDLE cycle right after DONE
   task automatic test_back_to_back();
      int first, second;
      first = -1; second = -1;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd0; opa_i = 32'd7; opb_i = 32'd6;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (ready_o) begin
            if (first < 0) begin
               first = c;
               checks++;
               if (result_o !== 64'd42) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 42", result_o); end
               checks++;
               if (stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_stall: got %b expected 0", stallreq_o); end
            end else if (second < 0) begin
               second = c;
               checks++;
               if (result_o !== 64'd4) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 4", result_o); end
            end
         end
         if (second >= 0) break;
         @(posedge clk); #1;
         if (first >= 0 && c == first) begin opa_i = 32'd2; opb_i = 32'd2; end
      end
      start_i = 1'b0;
      checks++;
      if (first !== 33) begin errors++; $display("[TB] FAIL b2b_first_cycle: got %0d expected 33", first); end
      checks++;
      if (second !== 67) begin errors++; $display("[TB] FAIL b2b_interval: got %0d expected 67", second); end
      repeat (3) @(posedge clk);
   endtask

   // Randomized ops with corner operands, compared against the model
   task automatic test_random();
      int rc, rn, sc, exp_cyc;
      logic [2:0]  op;
      logic [31:0] a, b, h, l;
      logic [63:0] res, exp_res;
      for (int i = 0; i < 24; i++) begin
`ifdef EX_MULDIV_MACC_EN
         op = 3'($urandom_range(0, 7));
`else
         op = 3'($urandom_range(0, 3));
`endif
         a = $urandom;
         b = $urandom;
         h = $urandom;
         l = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         exp_res = ref_model(op, a, b, h, l);
         exp_cyc = ((op == 3'd2 || op == 3'd3) && b == 32'd0) ? 1 : 33;
         run_op(op, a, b, h, l, 60, rc, rn, sc, res);
         checks++;
         if (res !== exp_res) begin
            errors++;
            $display("[TB] FAIL random_result op=%0d a=%h b=%h h=%h l=%h: got %h expected %h", op, a, b, h, l, res, exp_res);
         end
         checks++;
         if (rc !== exp_cyc || rn !== 1) begin
            errors++;
            $display("[TB] FAIL random_timing op=%0d: ready at %0d x%0d expected %0d x1", op, rc, rn, exp_cyc);
         end
      end
   endtask

   // Test sequence
   initial begin
      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd0;
      opa_i = 32'd0; opb_i = 32'd0; hi_i = 32'd0; lo_i = 32'd0;
      test_reset();
      test_mult();
      test_divide();
      test_div_by_zero();
      test_annul();
      test_reset_mid();
      test_multu();
      test_macc();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
